// File: rtl/alu_muldiv_seq_if.sv
// Request/response and shared-ALU signal bundle for the multiply/divide sequencer.
// The sequencer connects through the slave modport; the decoder/ALU side uses master.
interface alu_muldiv_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;
  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic             alu_Cin;
  logic [2:0]       alu_Op;
  logic             alu_invA;
  logic             alu_invB;
  logic             alu_sign;
  logic [WIDTH-1:0] alu_Out;
  logic             alu_Ofl;

  modport master (
    output start, mode, opa, opb, alu_Out, alu_Ofl,
    input  busy, done, result_lo, result_hi, div_by_zero,
    input  alu_A, alu_B, alu_Cin, alu_Op, alu_invA, alu_invB, alu_sign
  );

  modport slave (
    input  start, mode, opa, opb, alu_Out, alu_Ofl,
    output busy, done, result_lo, result_hi, div_by_zero,
    output alu_A, alu_B, alu_Cin, alu_Op, alu_invA, alu_invB, alu_sign
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) and divide (restoring) sequencer that
// borrows the shared ALU for one add/subtract per RUN cycle.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  alu_muldiv_seq_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_dz, w_dz_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;   // H (MUL) / R (DIV)
  logic [WIDTH-1:0] r_lo, w_lo_nxt;   // L (MUL) / Q (DIV)
  logic [WIDTH-1:0] r_op, w_op_nxt;   // M (MUL) / D (DIV)
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_div_by_zero, w_div_by_zero_nxt;
  logic [WIDTH-1:0] r_result_lo, w_result_lo_nxt;
  logic [WIDTH-1:0] r_result_hi, w_result_hi_nxt;
  logic [WIDTH-1:0] w_rs;

  assign w_rs = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_mode        <= 1'b0;
      r_dz          <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_op          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_result_lo   <= '0;
      r_result_hi   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_mode        <= w_mode_nxt;
      r_dz          <= w_dz_nxt;
      r_hi          <= w_hi_nxt;
      r_lo          <= w_lo_nxt;
      r_op          <= w_op_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_div_by_zero <= w_div_by_zero_nxt;
      r_result_lo   <= w_result_lo_nxt;
      r_result_hi   <= w_result_hi_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_count_nxt       = r_count;
    w_mode_nxt        = r_mode;
    w_dz_nxt          = r_dz;
    w_hi_nxt          = r_hi;
    w_lo_nxt          = r_lo;
    w_op_nxt          = r_op;
    w_busy_nxt        = r_busy;
    w_done_nxt        = 1'b0;
    w_div_by_zero_nxt = r_div_by_zero;
    w_result_lo_nxt   = r_result_lo;
    w_result_hi_nxt   = r_result_hi;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_mode_nxt        = bus.mode;
          w_dz_nxt          = bus.mode & (bus.opb == '0);
          w_count_nxt       = '0;
          w_hi_nxt          = '0;
          w_lo_nxt          = bus.mode ? bus.opa : bus.opb;
          w_op_nxt          = bus.mode ? bus.opb : bus.opa;
          w_busy_nxt        = 1'b1;
          w_div_by_zero_nxt = 1'b0;
          w_state_nxt       = (bus.mode && (bus.opb == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_mode) begin
          // Restoring step: keep the difference when Rs >= D (carry or shifted-out MSB).
          if (r_hi[WIDTH-1] | bus.alu_Ofl) begin
            w_hi_nxt = bus.alu_Out;
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            w_hi_nxt = w_rs;
            w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          w_hi_nxt = {bus.alu_Ofl, bus.alu_Out[WIDTH-1:1]};
          w_lo_nxt = {bus.alu_Out[0], r_lo[WIDTH-1:1]};
        end
        w_count_nxt = r_count + CNT_W'(1);
        if (r_count == CNT_W'(WIDTH - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done_nxt        = 1'b1;
        w_busy_nxt        = 1'b0;
        w_div_by_zero_nxt = r_dz;
        w_result_lo_nxt   = r_dz ? '1 : r_lo;
        w_result_hi_nxt   = r_dz ? r_lo : r_hi;
        w_state_nxt       = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ALU operands are only driven in RUN; otherwise the ALU is left free (all zero).
  always_comb begin
    bus.alu_A    = '0;
    bus.alu_B    = '0;
    bus.alu_Cin  = 1'b0;
    bus.alu_invB = 1'b0;
    if (r_state == S_RUN) begin
      if (r_mode) begin
        bus.alu_A    = w_rs;
        bus.alu_B    = r_op;
        bus.alu_Cin  = 1'b1;
        bus.alu_invB = 1'b1;
      end else begin
        bus.alu_A = r_hi;
        bus.alu_B = r_lo[0] ? r_op : '0;
      end
    end
  end

  assign bus.alu_Op      = 3'b000;
  assign bus.alu_invA    = 1'b0;
  assign bus.alu_sign    = 1'b0;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.result_lo   = r_result_lo;
  assign bus.result_hi   = r_result_hi;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: vector table of MUL/DIV ops plus an
// ignored-start / mid-run reset sequence. Includes a behavioural shared ALU.
module tb_alu_muldiv_seq;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_muldiv_seq_if #(.WIDTH(16)) bus ();

  alu_muldiv_seq #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared 16-bit ALU in add mode with unsigned carry out.
  logic [16:0] w_sum;
  always_comb begin
    w_sum = {1'b0, (bus.alu_invA ? ~bus.alu_A : bus.alu_A)}
          + {1'b0, (bus.alu_invB ? ~bus.alu_B : bus.alu_B)}
          + 17'(bus.alu_Cin);
    bus.alu_Out = w_sum[15:0];
    bus.alu_Ofl = w_sum[16];
  end

  typedef struct {
    string       name;
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one op, then count rising edges until done (edge 0 = accept).
  task automatic run_op(input string nm, input logic m, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] lo,
                        input logic [15:0] hi, input logic dz, input int lat);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.opa   = 16'hDEAD;
    bus.opb   = 16'hBEEF;
    chk({nm, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    chk({nm, " done_low_after_accept"}, 32'(bus.done), 32'd0);
    chk({nm, " dz_cleared_on_accept"}, 32'(bus.div_by_zero), 32'd0);
    if (lat > 1) chk({nm, " alu_invB_in_run"}, 32'(bus.alu_invB), 32'(m));
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) break;
    end
    chk({nm, " latency"}, 32'(n), 32'(lat));
    if (n <= 40) begin
      chk({nm, " result_lo"}, 32'(bus.result_lo), 32'(lo));
      chk({nm, " result_hi"}, 32'(bus.result_hi), 32'(hi));
      chk({nm, " div_by_zero"}, 32'(bus.div_by_zero), 32'(dz));
      chk({nm, " busy_low_at_done"}, 32'(bus.busy), 32'd0);
      chk({nm, " alu_A_idle"}, 32'(bus.alu_A), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " busy"}, 32'(bus.busy), 32'd0);
    chk({nm, " done"}, 32'(bus.done), 32'd0);
    chk({nm, " result_lo"}, 32'(bus.result_lo), 32'd0);
    chk({nm, " result_hi"}, 32'(bus.result_hi), 32'd0);
    chk({nm, " div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
    chk({nm, " alu_A"}, 32'(bus.alu_A), 32'd0);
    chk({nm, " alu_B"}, 32'(bus.alu_B), 32'd0);
    chk({nm, " alu_Cin"}, 32'(bus.alu_Cin), 32'd0);
    chk({nm, " alu_invB"}, 32'(bus.alu_invB), 32'd0);
    chk({nm, " alu_ctrl"}, 32'({bus.alu_Op, bus.alu_invA, bus.alu_sign}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dcount;
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{"mul_3x5",       1'b0, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 17};
    vecs[1] = '{"mul_ffff_sq",   1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17};
    vecs[2] = '{"mul_1234x100",  1'b0, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b0, 17};
    vecs[3] = '{"mul_zero",      1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 17};
    vecs[4] = '{"div_100_7",     1'b1, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17};
    vecs[5] = '{"div_8000_3",    1'b1, 16'h8000, 16'h0003, 16'h2AAA, 16'h0002, 1'b0, 17};
    vecs[6] = '{"div_ffff_8001", 1'b1, 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 17};
    vecs[7] = '{"div_by_zero",   1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1};
    vecs[8] = '{"div_5_9",       1'b1, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 17};
    vecs[9] = '{"div_ffff_1",    1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.opa   = 16'h0000;
    bus.opb   = 16'h0000;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ops: each start lands in the first IDLE cycle after done.
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b,
             vecs[i].lo, vecs[i].hi, vecs[i].dz, vecs[i].lat);

    // MUL in flight, stray DIV-by-zero start at cycle 5, reset at cycle 9.
    dcount = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.opa   = 16'd7;
    bus.opb   = 16'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done) dcount++;
    end
    bus.start = 1'b1;
    bus.mode  = 1'b1;
    bus.opa   = 16'h1234;
    bus.opb   = 16'h0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (bus.done) dcount++;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) dcount++;
    end
    chk("ignored_start busy", 32'(bus.busy), 32'd1);
    chk("ignored_start still_mul", 32'(bus.alu_invB), 32'd0);
    chk("ignored_start no_done", 32'(dcount), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done) dcount++;
    end
    chk("midrun_reset no_done_pulse", 32'(dcount), 32'd0);
    chk("midrun_reset idle_busy", 32'(bus.busy), 32'd0);

    run_op("mul_2x2_after_reset", 1'b0, 16'd2, 16'd2, 16'd4, 16'd0, 1'b0, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
